// File: rtl/pe_dma_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_dma_arb_pkg
// Purpose  : Shared types, default widths and round-robin helper for the
//            PE DMA-to-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package pe_dma_arb_pkg;

  localparam int unsigned MAX_CHAN            = 16;
  localparam int unsigned DEF_NUM_CHAN        = 4;
  localparam int unsigned DEF_ADDR_W          = 24;
  localparam int unsigned DEF_DATA_W          = 64;
  localparam int unsigned DEF_MAX_OUTSTANDING = 8;

  typedef enum logic [0:0] {
    IDLE_RR = 1'b0,
    LOCKED  = 1'b1
  } arb_state_e;

  // First requester at or after ptr, wrapping at n; returns ptr when nobody requests.
  function automatic logic [3:0] rr_pick(input logic [MAX_CHAN-1:0] req,
                                         input logic [3:0]          ptr,
                                         input int unsigned         n);
    logic       found;
    logic [4:0] sum;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < MAX_CHAN; k++) begin
      if (k < n) begin
        sum = {1'b0, ptr} + 5'(k);
        if (sum >= 5'(n)) sum = sum - 5'(n);
        if (!found && req[sum[3:0]]) begin
          found   = 1'b1;
          rr_pick = sum[3:0];
        end
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_dma_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pe_dma_tag_fifo
// Purpose  : Synchronous FIFO holding the channel tag of every read still
//            waiting for its memory response.
// Revision : 1.0 - initial release
// ============================================================================
module pe_dma_tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             w_push_ok, w_pop_ok;

  assign o_full     = (count_q == (PTR_W+1)'(DEPTH));
  assign o_empty    = (count_q == '0);
  assign o_pop_data = mem_q[rd_ptr_q];

  // Pointer, occupancy and storage update; full/empty judged on the current count.
  always_comb begin
    w_push_ok = i_push & ~o_full;
    w_pop_ok  = i_pop & ~o_empty;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (w_push_ok) begin
      mem_d[wr_ptr_q] = i_push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (w_push_ok && !w_pop_ok)      count_d = count_q + (PTR_W+1)'(1);
    else if (!w_push_ok && w_pop_ok) count_d = count_q - (PTR_W+1)'(1);
  end

  // Register pointers and count; storage needs no reset since empty masks it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pe_dma_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pe_dma_mem_arbiter
// Purpose  : Round-robin, burst-locking arbiter of NUM_CHAN DMA request
//            streams onto one memory port, with in-order read response
//            routing back to the originating channel.
// Revision : 1.0 - initial release
// ============================================================================
module pe_dma_mem_arbiter
  import pe_dma_arb_pkg::*;
#(
  parameter int unsigned NUM_CHAN        = DEF_NUM_CHAN,
  parameter int unsigned ADDR_W          = DEF_ADDR_W,
  parameter int unsigned DATA_W          = DEF_DATA_W,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                         clk,
  input  logic                         reset_poweron,
  input  logic [NUM_CHAN-1:0]          dma_req_valid,
  input  logic [NUM_CHAN-1:0]          dma_req_wr,
  input  logic [NUM_CHAN-1:0]          dma_req_last,
  input  logic [NUM_CHAN*ADDR_W-1:0]   dma_req_addr,
  input  logic [NUM_CHAN*DATA_W-1:0]   dma_req_wdata,
  output logic [NUM_CHAN-1:0]          dma_req_ready,
  output logic                         mem_req_valid,
  output logic                         mem_req_wr,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic [DATA_W-1:0]            mem_req_wdata,
  input  logic                         mem_req_ready,
  input  logic                         mem_rsp_valid,
  input  logic [DATA_W-1:0]            mem_rsp_data,
  output logic [NUM_CHAN-1:0]          dma_rsp_valid,
  output logic [DATA_W-1:0]            dma_rsp_data,
  output logic                         err_rsp_unexpected
);

  localparam int unsigned      TAG_W       = $clog2(NUM_CHAN);
  localparam logic [TAG_W-1:0] c_last_chan = TAG_W'(NUM_CHAN - 1);

  arb_state_e          state_q, state_d;
  logic [TAG_W-1:0]    rr_ptr_q, rr_ptr_d, lock_chan_q, lock_chan_d;
  logic                mem_req_valid_q, mem_req_valid_d, mem_req_wr_q, mem_req_wr_d;
  logic [ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;
  logic [DATA_W-1:0]   mem_req_wdata_q, mem_req_wdata_d;
  logic [NUM_CHAN-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                err_q, err_d;

  logic [TAG_W-1:0]    w_grant_idx, w_head_tag;
  logic                w_grant_any, w_can_load, w_hs, w_push, w_pop;
  logic                w_tag_full, w_tag_empty;
  logic                w_sel_wr, w_sel_last;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  assign mem_req_valid      = mem_req_valid_q;
  assign mem_req_wr         = mem_req_wr_q;
  assign mem_req_addr       = mem_req_addr_q;
  assign mem_req_wdata      = mem_req_wdata_q;
  assign dma_rsp_valid      = rsp_valid_q;
  assign dma_rsp_data       = rsp_data_q;
  assign err_rsp_unexpected = err_q;

  // Grant selection: locked channel wins unconditionally, otherwise round-robin.
  always_comb begin
    if (state_q == LOCKED) begin
      w_grant_idx = lock_chan_q;
      w_grant_any = 1'b1;
    end else begin
      w_grant_idx = TAG_W'(rr_pick(MAX_CHAN'(dma_req_valid), 4'(rr_ptr_q), NUM_CHAN));
      w_grant_any = |dma_req_valid;
    end
  end

  assign w_can_load = ~mem_req_valid_q | mem_req_ready;

  // A read stalls on a full tag FIFO without passing the grant to anyone else.
  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_ready
    assign dma_req_ready[i] = w_grant_any && (w_grant_idx == TAG_W'(i)) && w_can_load
                              && (dma_req_wr[i] || !w_tag_full);
  end

  assign w_hs = |(dma_req_valid & dma_req_ready);

  // Mux out the granted channel's request fields.
  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_CHAN; i++) begin
      if (w_grant_idx == TAG_W'(i)) begin
        w_sel_wr    = dma_req_wr[i];
        w_sel_last  = dma_req_last[i];
        w_sel_addr  = dma_req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = dma_req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Arbiter next state: lock on a non-last beat, advance the RR pointer on the last.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_chan_d = lock_chan_q;
    if (w_hs) begin
      if (w_sel_last) begin
        state_d  = IDLE_RR;
        rr_ptr_d = (w_grant_idx == c_last_chan) ? '0 : w_grant_idx + TAG_W'(1);
      end else begin
        state_d     = LOCKED;
        lock_chan_d = w_grant_idx;
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q     <= IDLE_RR;
      rr_ptr_q    <= '0;
      lock_chan_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_chan_q <= lock_chan_d;
    end
  end

  assign w_push = w_hs & ~w_sel_wr;
  assign w_pop  = mem_rsp_valid & ~w_tag_empty;

  pe_dma_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (reset_poweron),
    .i_push      (w_push),
    .i_push_data (w_grant_idx),
    .i_pop       (w_pop),
    .o_pop_data  (w_head_tag),
    .o_full      (w_tag_full),
    .o_empty     (w_tag_empty)
  );

  // Output request register and response/error path next values.
  always_comb begin
    mem_req_valid_d = mem_req_valid_q;
    mem_req_wr_d    = mem_req_wr_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_wdata_d = mem_req_wdata_q;
    if (w_can_load) begin
      mem_req_valid_d = w_hs;
      if (w_hs) begin
        mem_req_wr_d    = w_sel_wr;
        mem_req_addr_d  = w_sel_addr;
        mem_req_wdata_d = w_sel_wdata;
      end
    end
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (w_pop) begin
      rsp_valid_d = NUM_CHAN'(1) << w_head_tag;
      rsp_data_d  = mem_rsp_data;
    end
    err_d = err_q | (mem_rsp_valid & w_tag_empty);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      mem_req_valid_q <= 1'b0;
      mem_req_wr_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      rsp_valid_q     <= '0;
      rsp_data_q      <= '0;
      err_q           <= 1'b0;
    end else begin
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_wr_q    <= mem_req_wr_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      err_q           <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/pe_dma_mem_arbiter.md
Name: pe_dma_mem_arbiter

Overview:
Parametrised N-channel successor to the single-channel DMA-to-memory path of the PE.
- Arbitrates NUM_CHAN DMA request streams onto one memory-controller request port, round-robin, with burst locking.
- Returns in-order read responses to the originating channel through an outstanding-read tag FIFO.
- Sits between the PE DMA engines and the PE memory controller.

Parameters:
NUM_CHAN, 4, number of DMA request channels (2..16)
ADDR_W, 24, memory word address width
DATA_W, 64, data width of write data and read response
MAX_OUTSTANDING, 8, depth of the outstanding-read tag FIFO (power of 2)
TAG_W, $clog2(NUM_CHAN), channel-tag width (derived, not overridable)

Ports:
clk  in  1  single clock; all logic rising-edge
reset_poweron  in  1  synchronous, active-high reset
dma_req_valid  in  NUM_CHAN  per-channel request valid
dma_req_wr  in  NUM_CHAN  1=write, 0=read
dma_req_last  in  NUM_CHAN  last beat of burst; releases lock
dma_req_addr  in  NUM_CHAN*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W]
dma_req_wdata  in  NUM_CHAN*DATA_W  per-channel write data
dma_req_ready  out  NUM_CHAN  per-channel accept
mem_req_valid  out  1  request to memory controller
mem_req_wr  out  1  write/read
mem_req_addr  out  ADDR_W  address
mem_req_wdata  out  DATA_W  write data
mem_req_ready  in  1  memory controller accepts
mem_rsp_valid  in  1  read response, strictly in request order
mem_rsp_data  in  DATA_W  read data
dma_rsp_valid  out  NUM_CHAN  one-hot response strobe to owning channel
dma_rsp_data  out  DATA_W  response data, shared by all channels
err_rsp_unexpected  out  1  sticky: response arrived with no outstanding read

Behaviour:
Reset (synchronous, active-high):
- All outputs 0.
- RR pointer = 0; lock cleared; output register empty; tag FIFO empty; err cleared.
- Reset mid-operation discards buffered requests and outstanding tags. Responses arriving after reset raise err.

Request path:
- A handshake occurs when dma_req_valid[i] & dma_req_ready[i].
- One-entry output register drives mem_req_*. It loads on handshake and holds until mem_req_valid & mem_req_ready.
- can_load = !mem_req_valid | mem_req_ready. This gives full throughput: one request per cycle while mem_req_ready=1.
- Latency: handshake in cycle N -> mem_req_valid=1 in cycle N+1.
- dma_req_ready[i] = grant[i] & can_load & (dma_req_wr[i] | !tag_full).
- ready is combinational from valid. No channel is ready when grant is 0.
- Read blocked by a full tag FIFO: the grant holds on that channel. There is no bypass to other channels, preserving RR fairness.

Arbitration, states IDLE_RR / LOCKED:
- IDLE_RR: grant is the first requesting channel at or after rr_ptr, wrapping NUM_CHAN-1 -> 0.
- On a handshake with last=1: rr_ptr = granted+1 mod NUM_CHAN; stay IDLE_RR.
- On a handshake with last=0: lock_chan = granted; go to LOCKED.
- LOCKED: grant = lock_chan only, even if its valid is low; other channels stall.
- In LOCKED, a handshake with last=1 sets rr_ptr = lock_chan+1 and returns to IDLE_RR.
- A single-beat request is simply last=1.

Response path:
- Tag FIFO pushes the channel index on each accepted read handshake.
- mem_rsp_valid pops the head tag. In the next cycle, dma_rsp_valid[tag]=1 and dma_rsp_data = registered mem_rsp_data (1-cycle latency, no backpressure).
- Simultaneous push and pop: both occur, and the count is unchanged.
- tag_full is computed before the pop. A full FIFO refuses a push even if a pop occurs in the same cycle.
- mem_rsp_valid with the FIFO empty: data dropped; dma_rsp_valid stays 0; err_rsp_unexpected=1 until reset.
- Writes produce no tag and no response.

Decomposition:
- Shared package pe_dma_arb_pkg: arb_state_e {IDLE_RR, LOCKED}, default widths, function rr_pick(req, ptr).
- One sub-module: pe_dma_tag_fifo. Synchronous FIFO, width TAG_W, depth MAX_OUTSTANDING, with full/empty flags.

Test Plan:
1. Reset then idle -> all outputs 0, and dma_req_ready=0 with no valid.
2. Channels 0-3 all valid, last=1, mem_req_ready=1 -> grants in order 0,1,2,3,0; one mem_req per cycle; mem_req_valid 1 cycle after each handshake.
3. Ch1 4-beat burst (last on beat 4) while ch2 valid -> ch2 stalled until ch1 beat 4, then ch2 granted; rr_ptr=2 after ch1.
4. MAX_OUTSTANDING=8: ch0 issues 9 reads with no responses -> 9th ready=0. One mem_rsp pops tag 0 -> dma_rsp_valid=4'b0001 next cycle; 9th read accepted the cycle after.
5. mem_req_ready low for 3 cycles with request pending -> mem_req_* stable; dma_req_ready=0 for all; resumes without loss.
6. mem_rsp_valid with empty FIFO, data 0xDEAD -> no dma_rsp_valid; err_rsp_unexpected=1 until reset_poweron.
